// File: rtl/alarm_clock_controller.sv
// Time-keeping and alarm sequencer.
// Keeps the running HH:MM:SS time and the HH:MM alarm. Routes hours/mins
// increment pulses to either the time or the alarm registers, and runs the
// ring / snooze / stop sequence that drives the buzzer.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   sec_tick              one-cycle pulse per second
//   alarm_mode            1: increments edit alarm, 0: increments edit time
//   hours_inc, mins_inc   one-cycle increment pulses
//   alarm_en              level; 0 disarms the alarm and silences any ring
//   snooze, stop          one-cycle button pulses
//   time_h/m/s            current time
//   alarm_h/m             alarm setting
//   ring                  buzzer drive (RINGING)
//   snoozed               high while SNOOZED
module alarm_clock_controller #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_MINS = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sec_tick,
  input  logic       alarm_mode,
  input  logic       hours_inc,
  input  logic       mins_inc,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [4:0] time_h,
  output logic [5:0] time_m,
  output logic [5:0] time_s,
  output logic [4:0] alarm_h,
  output logic [5:0] alarm_m,
  output logic       ring,
  output logic       snoozed
);

  typedef enum logic [1:0] {StIdle, StRinging, StSnoozed} state_e;

  state_e     state_q, state_d;
  logic [4:0] time_h_q, time_h_d;
  logic [5:0] time_m_q, time_m_d;
  logic [5:0] time_s_q, time_s_d;
  logic [4:0] alarm_h_q, alarm_h_d;
  logic [5:0] alarm_m_q, alarm_m_d;
  logic [4:0] snz_h_q, snz_h_d;
  logic [5:0] snz_m_q, snz_m_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic       ring_q, snoozed_q;

  logic       time_edit;
  logic       min_boundary;
  logic [6:0] snz_m_sum;
  logic [4:0] snz_h_calc;
  logic [5:0] snz_m_calc;

  assign time_edit = !alarm_mode && (hours_inc || mins_inc);

  // Time registers: an edit cycle swallows that cycle's sec_tick.
  always_comb begin
    time_h_d     = time_h_q;
    time_m_d     = time_m_q;
    time_s_d     = time_s_q;
    min_boundary = 1'b0;
    if (time_edit) begin
      if (mins_inc) begin
        time_m_d = (time_m_q == 6'd59) ? 6'd0 : time_m_q + 6'd1;
        time_s_d = 6'd0;
      end
      if (hours_inc) begin
        time_h_d = (time_h_q == 5'd23) ? 5'd0 : time_h_q + 5'd1;
      end
    end else if (sec_tick) begin
      if (time_s_q == 6'd59) begin
        time_s_d     = 6'd0;
        min_boundary = 1'b1;
        if (time_m_q == 6'd59) begin
          time_m_d = 6'd0;
          time_h_d = (time_h_q == 5'd23) ? 5'd0 : time_h_q + 5'd1;
        end else begin
          time_m_d = time_m_q + 6'd1;
        end
      end else begin
        time_s_d = time_s_q + 6'd1;
      end
    end
  end

  // Alarm registers
  always_comb begin
    alarm_h_d = alarm_h_q;
    alarm_m_d = alarm_m_q;
    if (alarm_mode) begin
      if (mins_inc) alarm_m_d = (alarm_m_q == 6'd59) ? 6'd0 : alarm_m_q + 6'd1;
      if (hours_inc) alarm_h_d = (alarm_h_q == 5'd23) ? 5'd0 : alarm_h_q + 5'd1;
    end
  end

  // Snooze target from the currently displayed h:m
  always_comb begin
    snz_m_sum  = {1'b0, time_m_q} + 7'(SNOOZE_MINS);
    snz_m_calc = snz_m_sum[5:0];
    snz_h_calc = time_h_q;
    if (snz_m_sum >= 7'd60) begin
      snz_m_calc = 6'(snz_m_sum - 7'd60);
      snz_h_calc = (time_h_q == 5'd23) ? 5'd0 : time_h_q + 5'd1;
    end
  end

  // Ring FSM; matches compare against the post-increment time.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_h_d    = snz_h_q;
    snz_m_d    = snz_m_q;
    if (!alarm_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (min_boundary && time_h_d == alarm_h_q && time_m_d == alarm_m_q) begin
            state_d    = StRinging;
            ring_cnt_d = 8'd0;
          end
        end
        StRinging: begin
          if (stop) begin
            state_d = StIdle;
          end else if (snooze) begin
            state_d = StSnoozed;
            snz_h_d = snz_h_calc;
            snz_m_d = snz_m_calc;
          end else if (sec_tick) begin
            if ((ring_cnt_q + 8'd1) == 8'(RING_SECS)) state_d = StIdle;
            else ring_cnt_d = ring_cnt_q + 8'd1;
          end
        end
        StSnoozed: begin
          if (stop) begin
            state_d = StIdle;
          end else if (min_boundary && time_h_d == snz_h_q && time_m_d == snz_m_q) begin
            state_d    = StRinging;
            ring_cnt_d = 8'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      time_h_q   <= '0;
      time_m_q   <= '0;
      time_s_q   <= '0;
      alarm_h_q  <= '0;
      alarm_m_q  <= '0;
      snz_h_q    <= '0;
      snz_m_q    <= '0;
      ring_cnt_q <= '0;
      ring_q     <= 1'b0;
      snoozed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_h_q   <= time_h_d;
      time_m_q   <= time_m_d;
      time_s_q   <= time_s_d;
      alarm_h_q  <= alarm_h_d;
      alarm_m_q  <= alarm_m_d;
      snz_h_q    <= snz_h_d;
      snz_m_q    <= snz_m_d;
      ring_cnt_q <= ring_cnt_d;
      ring_q     <= (state_d == StRinging);
      snoozed_q  <= (state_d == StSnoozed);
    end
  end

  assign time_h  = time_h_q;
  assign time_m  = time_m_q;
  assign time_s  = time_s_q;
  assign alarm_h = alarm_h_q;
  assign alarm_m = alarm_m_q;
  assign ring    = ring_q;
  assign snoozed = snoozed_q;

endmodule
